// File: rtl/tug_of_war_field.sv
// Tug-of-war playfield: one lit position moved by two players' press pulses,
// with round-win detection, per-player scores, hold-dark re-centring and match latch.
module tug_of_war_field #(
    parameter int NUM_LIGHTS  = 9,
    parameter int SCORE_W     = 3,
    parameter int WIN_SCORE   = 7,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  L,
    input  logic                  R,
    output logic [NUM_LIGHTS-1:0] lights,
    output logic                  round_win_l,
    output logic                  round_win_r,
    output logic [SCORE_W-1:0]    score_l,
    output logic [SCORE_W-1:0]    score_r,
    output logic                  match_over,
    output logic                  match_winner
);

    localparam int PW = $clog2(NUM_LIGHTS);
    localparam int HW = $clog2(HOLD_CYCLES) + 1;

    localparam logic [PW-1:0]         P_MAX  = PW'(NUM_LIGHTS - 1);
    localparam logic [PW-1:0]         P_MID  = PW'((NUM_LIGHTS - 1) / 2);
    localparam logic [HW-1:0]         H_LOAD = HW'(HOLD_CYCLES - 1);
    localparam logic [SCORE_W-1:0]    S_WIN  = SCORE_W'(WIN_SCORE);
    localparam logic [NUM_LIGHTS-1:0] ONE    = NUM_LIGHTS'(1);

    typedef enum logic [1:0] {S_PLAY, S_HOLD, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [PW-1:0]           pos_q, pos_d;
    logic [HW-1:0]           hold_q, hold_d;
    logic [SCORE_W-1:0]      sl_q, sl_d;
    logic [SCORE_W-1:0]      sr_q, sr_d;
    logic [NUM_LIGHTS-1:0]   lights_q, lights_d;
    logic                    wl_q, wl_d;
    logic                    wr_q, wr_d;
    logic                    over_q, over_d;
    logic                    winner_q, winner_d;
    logic                    win_l, win_r;
    logic                    l_only, r_only;

    assign l_only = L & ~R;
    assign r_only = R & ~L;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_PLAY;
            pos_q    <= P_MID;
            hold_q   <= '0;
            sl_q     <= '0;
            sr_q     <= '0;
            lights_q <= ONE << P_MID;
            wl_q     <= 1'b0;
            wr_q     <= 1'b0;
            over_q   <= 1'b0;
            winner_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            hold_q   <= hold_d;
            sl_q     <= sl_d;
            sr_q     <= sr_d;
            lights_q <= lights_d;
            wl_q     <= wl_d;
            wr_q     <= wr_d;
            over_q   <= over_d;
            winner_q <= winner_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        hold_d  = hold_q;
        sl_d    = sl_q;
        sr_d    = sr_q;
        win_l   = 1'b0;
        win_r   = 1'b0;
        unique case (state_q)
            S_PLAY: begin
                // Simultaneous presses cancel and fall to default.
                unique case (1'b1)
                    l_only: begin
                        if (pos_q == P_MAX) win_l = 1'b1;
                        else                pos_d = pos_q + 1'b1;
                    end
                    r_only: begin
                        if (pos_q == '0) win_r = 1'b1;
                        else             pos_d = pos_q - 1'b1;
                    end
                    default: ;
                endcase
                if (win_l) sl_d = sl_q + 1'b1;
                if (win_r) sr_d = sr_q + 1'b1;
                if (win_l || win_r) begin
                    if (sl_d == S_WIN || sr_d == S_WIN) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_HOLD;
                        hold_d  = H_LOAD;
                    end
                end
            end
            S_HOLD: begin
                if (hold_q == '0) begin
                    state_d = S_PLAY;
                    pos_d   = P_MID;
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            S_DONE: ;
            default: state_d = S_PLAY;
        endcase
    end

    always_comb begin
        lights_d = (state_d == S_PLAY) ? (ONE << pos_d) : '0;
        wl_d     = win_l;
        wr_d     = win_r;
        over_d   = over_q | (state_d == S_DONE);
        winner_d = winner_q;
        if (state_q != S_DONE && state_d == S_DONE) winner_d = win_l;
    end

    assign lights       = lights_q;
    assign round_win_l  = wl_q;
    assign round_win_r  = wr_q;
    assign score_l      = sl_q;
    assign score_r      = sr_q;
    assign match_over   = over_q;
    assign match_winner = winner_q;

endmodule
